// File: rtl/data_sram_responder.sv
// data_sram_responder: memory-side slave for the CPU data_sram port.
// Decodes every cycle's access into a word-addressed data RAM or a small
// MMIO register file (LED, switch, free-running timer, scratch).
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   data_sram_we      write enable for the access sampled this edge
//   data_sram_addr    byte address (addr[1:0] ignored)
//   data_sram_wdata   write data
//   data_sram_rdata   registered read data (old contents on a write)
//   switch            asynchronous board switches
//   led               LED register
`timescale 1ns/1ps

module data_sram_responder #(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [15:0] MMIO_HI = 16'hbfaf,
    parameter int unsigned LED_W   = 16,
    parameter int unsigned SW_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_sram_we,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    input  logic [SW_W-1:0]  switch,
    output logic [LED_W-1:0] led
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam logic [15:0] OFF_LED     = 16'hf000;
    localparam logic [15:0] OFF_SWITCH  = 16'hf010;
    localparam logic [15:0] OFF_TIMER   = 16'hf020;
    localparam logic [15:0] OFF_SCRATCH = 16'hf030;

    logic [31:0]       ram [RAM_DEPTH];
    logic [31:0]       timer;
    logic [31:0]       scratch;
    logic [SW_W-1:0]   sw_sync1;
    logic [SW_W-1:0]   sw_sync2;

    logic              mmio_sel_c;
    logic [15:0]       off_c;
    logic [RAM_AW-1:0] ram_idx_c;
    logic              ram_we_c;
    logic              led_we_c;
    logic              timer_we_c;
    logic              scratch_we_c;
    logic [31:0]       rd_c;

    // Address decode; upper RAM address bits alias onto the same words.
    assign mmio_sel_c   = (data_sram_addr[31:16] == MMIO_HI);
    assign off_c        = data_sram_addr[15:0];
    assign ram_idx_c    = data_sram_addr[RAM_AW+1:2];
    assign ram_we_c     = !reset && data_sram_we && !mmio_sel_c;
    assign led_we_c     = data_sram_we && mmio_sel_c && (off_c == OFF_LED);
    assign timer_we_c   = data_sram_we && mmio_sel_c && (off_c == OFF_TIMER);
    assign scratch_we_c = data_sram_we && mmio_sel_c && (off_c == OFF_SCRATCH);

    // Read mux; undecoded MMIO offsets read as zero.
    always_comb begin
        rd_c = '0;
        if (mmio_sel_c) begin
            case (off_c)
                OFF_LED:     rd_c = 32'(led);
                OFF_SWITCH:  rd_c = 32'(sw_sync2);
                OFF_TIMER:   rd_c = timer;
                OFF_SCRATCH: rd_c = scratch;
                default:     rd_c = '0;
            endcase
        end else begin
            rd_c = ram[ram_idx_c];
        end
    end

    // RAM array: contents survive reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[ram_idx_c] <= data_sram_wdata;
        end
    end

    // Registered read data, MMIO registers and switch synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sram_rdata <= '0;
            led             <= '0;
            timer           <= '0;
            scratch         <= '0;
            sw_sync1        <= '0;
            sw_sync2        <= '0;
        end else begin
            data_sram_rdata <= rd_c;
            sw_sync1        <= switch;
            sw_sync2        <= sw_sync1;
            if (led_we_c) begin
                led <= data_sram_wdata[LED_W-1:0];
            end
            if (scratch_we_c) begin
                scratch <= data_sram_wdata;
            end
            // A timer write loads the value and skips that cycle's increment.
            if (timer_we_c) begin
                timer <= data_sram_wdata;
            end else begin
                timer <= timer + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: scoreboard bench for data_sram_responder.
// A driver issues one access per cycle and pushes the expected response
// from a reference model; a monitor pops and compares after each edge.
`timescale 1ns/1ps

module tb_data_sram_responder;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] alt;
        bit          dc;
        logic [15:0] led;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;

    int checks;
    int failures;

    sb_t         q[$];
    sb_t         mon_e;

    // Reference model state.
    logic [31:0] m_ram [int];
    logic [31:0] m_timer;
    logic [31:0] m_scratch;
    logic [15:0] m_led;
    logic [7:0]  h1, h2, h3;     // switch values at the last three edges
    logic [7:0]  sw_next;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch          (switch),
        .led             (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_timer   = '0;
        m_scratch = '0;
        m_led     = '0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    // One access per call: drive at negedge, predict, advance model.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd);
        sb_t         e;
        bit          mm;
        logic [15:0] off;
        int          k;
        @(negedge clk);
        data_sram_we    = we;
        data_sram_addr  = a;
        data_sram_wdata = wd;
        switch          = sw_next;
        mm  = (a[31:16] == 16'hbfaf);
        off = a[15:0];
        k   = int'(a[13:2]);
        e.dc  = 1'b0;
        e.exp = 32'h0;
        if (mm) begin
            case (off)
                16'hf000: e.exp = {16'h0, m_led};
                16'hf010: e.exp = {24'h0, h2};
                16'hf020: e.exp = m_timer;
                16'hf030: e.exp = m_scratch;
                default:  e.exp = 32'h0;
            endcase
        end else if (m_ram.exists(k)) begin
            e.exp = m_ram[k];
        end else begin
            e.dc = 1'b1;
        end
        e.alt = e.exp;
        if (mm && off == 16'hf010) e.alt = {24'h0, h3};
        // State updates take effect after the edge.
        if (mm && we && off == 16'hf020) m_timer = wd;
        else                             m_timer = m_timer + 1;
        if (mm && we && off == 16'hf000) m_led = wd[15:0];
        if (mm && we && off == 16'hf030) m_scratch = wd;
        if (!mm && we) m_ram[k] = wd;
        h3 = h2; h2 = h1; h1 = sw_next;
        e.led = m_led;
        q.push_back(e);
    endtask

    // Monitor: one response per edge while out of reset.
    always @(posedge clk) begin
        #1;
        if (!reset && q.size() > 0) begin
            mon_e = q.pop_front();
            if (!mon_e.dc) begin
                checks++;
                if (data_sram_rdata !== mon_e.exp && data_sram_rdata !== mon_e.alt) begin
                    failures++;
                    $display("FAIL rdata addr=%h got=%h want=%h (or %h)",
                             data_sram_addr, data_sram_rdata, mon_e.exp, mon_e.alt);
                end
            end
            checks++;
            if (led !== mon_e.led) begin
                failures++;
                $display("FAIL led got=%h want=%h", led, mon_e.led);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] offs [6];
        logic [31:0] a;
        int          r;
        checks = 0;
        failures = 0;
        offs[0] = 16'hf000; offs[1] = 16'hf010; offs[2] = 16'hf020;
        offs[3] = 16'hf030; offs[4] = 16'hf040; offs[5] = 16'h0;
        reset = 1'b1;
        data_sram_we = 1'b0;
        data_sram_addr = '0;
        data_sram_wdata = '0;
        sw_next = '0;
        switch = '0;
        model_reset();

        #1;
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h want=0", data_sram_rdata);
        end
        checks++;
        if (led !== 16'h0) begin
            failures++; $display("FAIL reset_led got=%h want=0", led);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // RAM write/read and aliasing.
        access(1, 32'h0000_0010, 32'h1234_5678);
        access(0, 32'h0000_0010, 32'h0);
        access(0, 32'h0000_4010, 32'h0);
        // Read-before-write.
        access(1, 32'h0000_0010, 32'haaaa_aaaa);
        access(1, 32'h0000_0010, 32'h5555_5555);
        access(0, 32'h0000_0010, 32'h0);
        // LED / SCRATCH / undecoded / SWITCH write ignored.
        access(1, 32'hbfaf_f000, 32'hdead_beef);
        access(0, 32'hbfaf_f000, 32'h0);
        access(1, 32'hbfaf_f030, 32'hcafe_f00d);
        access(0, 32'hbfaf_f030, 32'h0);
        access(0, 32'hbfaf_f040, 32'h0);
        access(1, 32'hbfaf_f010, 32'hffff_ffff);
        access(0, 32'hbfaf_f010, 32'h0);
        // Timer load and wrap.
        access(1, 32'hbfaf_f020, 32'hffff_fffe);
        repeat (3) access(0, 32'hbfaf_f020, 32'h0);
        // Switch synchroniser.
        sw_next = 8'h5a;
        repeat (5) access(0, 32'hbfaf_f010, 32'h0);

        // Reset mid-operation.
        access(1, 32'h0000_0100, 32'h0000_0077);
        access(1, 32'hbfaf_f000, 32'h1234_abcd);
        access(0, 32'hbfaf_f020, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            failures++; $display("FAIL midreset_rdata got=%h want=0", data_sram_rdata);
        end
        checks++;
        if (led !== 16'h0) begin
            failures++; $display("FAIL midreset_led got=%h want=0", led);
        end
        data_sram_we = 1'b1;
        data_sram_addr = 32'hbfaf_f000;
        data_sram_wdata = 32'hffff_ffff;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        access(0, 32'hbfaf_f020, 32'h0);
        access(0, 32'hbfaf_f020, 32'h0);
        access(0, 32'hbfaf_f000, 32'h0);
        access(0, 32'h0000_0100, 32'h0);

        // Prefill a RAM pool, then random traffic.
        for (int i = 0; i < 16; i++) begin
            access(1, {16'h0, 2'b00, 12'(i * 257), 2'b00}, $urandom);
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) sw_next = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                a = {16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     12'($urandom_range(0, 15) * 257), 2'($urandom_range(0, 3))};
            end else begin
                a = {16'hbfaf, offs[$urandom_range(0, 5)]};
                if (a[15:0] == 16'h0) a[15:0] = 16'($urandom);
            end
            access(1'($urandom_range(0, 1)), a, $urandom);
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++; $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
